hps_fpga_button_pio: RTL
========================

Name: hps_fpga_button_pio

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
- Samples WIDTH external inputs (push-buttons/switches) on the FPGA fabric and synchronizes and debounces each bit.
- Captures selected edges per bit and raises a maskable level interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge beside the LED PIO.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles needed before the debounced value changes (>=1).
- EDGE_TYPE, 0, capture edge select: 0 = falling (active-low buttons), 1 = rising, 2 = any.
- RESET_LEVEL, all-ones, reset value of the synchronizer and debounced register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset (async, reset_n=0):
  - sync stages and debounced value = RESET_LEVEL.
  - debounce counters = 0.
  - irq_mask = 0, edge_capture = 0.
  - readdata = 0, irq = 0.
- Synchronizer:
  - Two flops per bit on in_port; sync_q is the second stage.
  - Adds 2 cycles of latency.
- Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES+1):
  - If sync_q == deb: counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, deb takes sync_q next cycle and the counter clears.
  - Any return to match before that point clears the counter, so a glitch shorter than DEBOUNCE_CYCLES is never seen.
  - Total in_port-to-deb latency = 2 + DEBOUNCE_CYCLES cycles.
- Edge detect:
  - deb_prev <= deb every cycle.
  - Falling edge = deb_prev & ~deb; rising edge = ~deb_prev & deb; any edge = XOR.
  - Detected edge bits are selected by EDGE_TYPE.
- Register map (byte offset = address*4):
  - 0 DATA, read-only: {0, deb}. Writes are ignored.
  - 1 Reserved: reads 0, writes ignored.
  - 2 IRQMASK, read/write: bits [WIDTH-1:0]. Upper writedata bits are ignored.
  - 3 EDGECAP, read / write-1-to-clear: bits [WIDTH-1:0].
- Write: takes effect when chipselect & ~write_n at the clk edge; the new value is visible the next cycle.
- Read:
  - readdata is registered and updated every cycle from address (chipselect not required for the mux), giving read latency 1.
  - Unused upper bits read 0.
- edge_capture bit i update rule:
  - If a detected edge on bit i occurs, the bit sets to 1.
  - Otherwise, if an EDGECAP write has writedata[i]=1, the bit clears.
  - Otherwise it holds.
  - A set in the same cycle as a clear wins: the edge is never lost.
- irq:
  - Registered: irq <= |(edge_capture & irq_mask).
  - Asserts 1 cycle after the capture bit sets; drops 1 cycle after the clearing write (or a mask write to 0).
- Reset mid-debounce: the count is discarded, deb returns to RESET_LEVEL, and no edge is reported for the reset transition itself.
- An input held at a level other than RESET_LEVEL across reset produces an edge after reset release plus 2+DEBOUNCE_CYCLES cycles. This is intended.

Decomposition:
- Shared package hps_fpga_pio_pkg holds:
  - register offset constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - EDGE_FALL/EDGE_RISE/EDGE_ANY encodings.
  - A clog2 function.
- One sub-module, hps_fpga_debounce: a single-bit 2-flop synchronizer plus debounce counter, parameterized by DEBOUNCE_CYCLES and RESET_VAL. It is instantiated WIDTH times by generate.
- The top level holds the edge detect, registers, read mux and irq.

Test Plan:
- Reset values: assert reset_n=0 mid-traffic -> readdata=0 and irq=0 immediately. After release, read addr0 = 0x0000000F, addr2 = 0, addr3 = 0 (WIDTH=4, DEBOUNCE_CYCLES=4).
- Glitch rejection: in_port[1] low for 3 cycles, then high -> addr0 stays 0xF and addr3 stays 0, with no irq.
- Debounced press: in_port[1] low and held. Required response:
  - addr0 reads 0xD starting 6 cycles later (2+4).
  - addr3 reads 0x2.
  - With mask 0x2 written beforehand, irq=1 one cycle after capture.
- W1C clear: write addr3 = 0x2 -> addr3 reads 0 and irq falls 1 cycle after the write. Writing 0x0 to addr3 leaves the bit set.
- Simultaneous set/clear: align a falling edge on bit 0 with the cycle of writing addr3 = 0x1 -> addr3 still reads 0x1 afterwards.
- Masking and data writes: with capture=0x4 and mask=0, irq stays 0. Writing mask 0xFFFFFFFF reads back 0xF and irq rises the next cycle. Writing 0x5 to addr0 leaves DATA unchanged.

Source files
------------

// File: rtl/hps_fpga_pio_pkg.sv
// Shared constants for the HPS-to-FPGA PIO blocks: register offsets,
// edge-select encodings and a constant-width helper.
package hps_fpga_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_FALL = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

  // Smallest r with 2**r >= v; callers pass v >= 2 so the result is >= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hps_fpga_debounce.sv
// One input bit: two-flop synchronizer followed by a stability counter that
// only lets the debounced value follow after DEBOUNCE_CYCLES mismatched cycles.
module hps_fpga_debounce
  import hps_fpga_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  localparam int unsigned        CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      deb    <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      // Any return to the debounced level discards the partial count.
      if (sync_q == deb) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb   <= sync_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hps_fpga_button_pio.sv
// Avalon-MM input PIO: debounced button/switch inputs, per-bit edge capture
// with write-1-to-clear, maskable level interrupt to the HPS.
module hps_fpga_button_pio
  import hps_fpga_pio_pkg::*;
#(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [DATA_W-1:0] readdata,
  output logic              irq
);

  logic [WIDTH-1:0]  deb;
  logic [WIDTH-1:0]  deb_prev_q;
  logic [WIDTH-1:0]  irq_mask_q;
  logic [WIDTH-1:0]  edge_capture_q;
  logic [WIDTH-1:0]  edge_c;
  logic [WIDTH-1:0]  clr_c;
  logic [WIDTH-1:0]  mask_nxt_c;
  logic [DATA_W-1:0] rdata_c;
  logic              wr_c;
  logic              unused_ok_c;

  for (genvar g = 0; g < int'(WIDTH); g++) begin : g_deb
    hps_fpga_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_LEVEL[g])
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[g]),
      .deb     (deb[g])
    );
  end

  assign wr_c        = chipselect & ~write_n;
  assign unused_ok_c = &{1'b0, writedata};

  // Edge select and write decode.
  always_comb begin
    edge_c     = '0;
    clr_c      = '0;
    mask_nxt_c = irq_mask_q;
    if (EDGE_TYPE == 32'(EDGE_RISE)) begin
      edge_c = ~deb_prev_q & deb;
    end else if (EDGE_TYPE == 32'(EDGE_ANY)) begin
      edge_c = deb_prev_q ^ deb;
    end else begin
      edge_c = deb_prev_q & ~deb;
    end
    if (wr_c && (address == ADDR_EDGECAP)) clr_c      = writedata[WIDTH-1:0];
    if (wr_c && (address == ADDR_IRQMASK)) mask_nxt_c = writedata[WIDTH-1:0];
  end

  // Read mux; chipselect is deliberately not part of the select.
  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_DATA:    rdata_c = DATA_W'(deb);
      ADDR_IRQMASK: rdata_c = DATA_W'(irq_mask_q);
      ADDR_EDGECAP: rdata_c = DATA_W'(edge_capture_q);
      default:      rdata_c = '0;
    endcase
  end

  // deb_prev resets with deb so the reset transition itself is never an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_prev_q     <= RESET_LEVEL;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata       <= '0;
      irq            <= 1'b0;
    end else begin
      deb_prev_q     <= deb;
      irq_mask_q     <= mask_nxt_c;
      edge_capture_q <= edge_c | (edge_capture_q & ~clr_c);
      readdata       <= rdata_c;
      irq            <= |(edge_capture_q & irq_mask_q);
    end
  end

endmodule
